jtag_uart_bridge: RTL and testbench

//  System-clock-side consumer of the JTAG data-register core: takes the latched 8-bit data /
//  3-bit command and update strobe from the TCK domain and executes host commands.

---
 rtl/jtag_uart_bridge.sv | 128 ++++++++++++
 tb/tb_jtag_uart_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_bridge.sv
// rtl/jtag_uart_bridge.sv - system-side executor for JTAG host commands with RX FIFO and TX holding register
module jtag_uart_bridge #(
    parameter int RX_DEPTH = 4,
    parameter int RX_AW    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 jtag_update_i,
    input  logic [7:0]           jtag_reg_q_i,
    input  logic [2:0]           jtag_reg_addr_q_i,
    output logic [7:0]           jtag_reg_d_o,
    output logic [2:0]           jtag_reg_addr_d_o,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [7:0]           tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 rx_overflow_o
);

    localparam logic [2:0]       CMD_RXWR  = 3'b001;
    localparam logic [2:0]       CMD_TXACK = 3'b010;
    localparam logic [2:0]       CMD_FLUSH = 3'b011;
    localparam logic [RX_AW:0]   CNT_FULL  = (RX_AW+1)'(RX_DEPTH);
    localparam logic [RX_AW:0]   CNT_ONE   = (RX_AW+1)'(1);
    localparam logic [RX_AW-1:0] PTR_ONE   = RX_AW'(1);

    // Update strobe crosses from TCK: two sync stages plus an edge-detect stage
    logic upd_s1_q, upd_s2_q, upd_s3_q;

    logic [7:0]       mem_q [RX_DEPTH];
    logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RX_AW:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pending_q, pending_d;
    logic [7:0]       txd_q, txd_d;
    logic [2:0]       status_q, status_d;

    logic strobe, cmd_rxwr, cmd_txack, cmd_flush;
    logic full, pop, push_ok, tx_load;

    // Command data/code are stable long before the strobe, so they are used unsynchronised
    assign strobe    = upd_s2_q & ~upd_s3_q;
    assign cmd_rxwr  = strobe && (jtag_reg_addr_q_i == CMD_RXWR);
    assign cmd_txack = strobe && (jtag_reg_addr_q_i == CMD_TXACK);
    assign cmd_flush = strobe && (jtag_reg_addr_q_i == CMD_FLUSH);

    assign full    = (count_q == CNT_FULL);
    // FLUSH overrides a simultaneous consumer pop
    assign pop     = rx_valid_o & rx_ready_i & ~cmd_flush;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands
    assign push_ok = cmd_rxwr & (~full | pop);
    assign tx_load = tx_valid_i & ~pending_q;

    assign rx_valid_o        = (count_q != '0);
    assign rx_data_o         = mem_q[rd_ptr_q];
    assign tx_ready_o        = ~pending_q;
    assign jtag_reg_d_o      = txd_q;
    assign jtag_reg_addr_d_o = status_q;
    assign rx_overflow_o     = ovf_q;

    // Next-state for FIFO bookkeeping, sticky overflow, TX holding register and capture status
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        pending_d = pending_q;
        txd_d     = txd_q;
        if (cmd_flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            pending_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_ok && !pop)      count_d = count_q + CNT_ONE;
            else if (!push_ok && pop) count_d = count_q - CNT_ONE;
            if (cmd_rxwr && full && !pop) ovf_d = 1'b1;
            if (cmd_txack) pending_d = 1'b0;
        end
        if (tx_load) begin
            txd_d     = tx_data_i;
            pending_d = 1'b1;
        end
        status_d = {ovf_d, (count_d == CNT_FULL), pending_d};
    end

    // State registers; reset also clears the synchroniser so an in-flight strobe is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_s1_q  <= 1'b0;
            upd_s2_q  <= 1'b0;
            upd_s3_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b0;
            txd_q     <= 8'h00;
            status_q  <= 3'b000;
        end else begin
            upd_s1_q  <= jtag_update_i;
            upd_s2_q  <= upd_s1_q;
            upd_s3_q  <= upd_s2_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            txd_q     <= txd_d;
            status_q  <= status_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads 0 while empty after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= jtag_reg_q_i;
        end
    end

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// tb/tb_jtag_uart_bridge.sv - self-checking bench for jtag_uart_bridge
module tb_jtag_uart_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       upd;
    logic [7:0] reg_q;
    logic [2:0] reg_addr;
    logic [7:0] reg_d;
    logic [2:0] status;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [2:0] code;
        logic [7:0] data;
        logic [2:0] exp_status;
        logic       exp_valid;
    } vec_t;
    vec_t tbl[5];

    jtag_uart_bridge #(.RX_DEPTH(DEPTH), .RX_AW(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .jtag_update_i    (upd),
        .jtag_reg_q_i     (reg_q),
        .jtag_reg_addr_q_i(reg_addr),
        .jtag_reg_d_o     (reg_d),
        .jtag_reg_addr_d_o(status),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_ready_i       (rx_ready),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .rx_overflow_o    (rx_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard model update for commands, then update pulse of 'hold' cycles
    task automatic jtag_cmd(input logic [2:0] code, input logic [7:0] d, input int hold, input int post);
        if (code == 3'b001 && rx_q.size() < DEPTH) rx_q.push_back(d);
        if (code == 3'b011) rx_q.delete();
        @(negedge clk);
        reg_addr = code;
        reg_q    = d;
        upd      = 1'b1;
        repeat (hold) @(negedge clk);
        upd = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    // Called at a negedge: compare head with scoreboard, then pop one byte
    task automatic pop_check(input string name);
        logic [7:0] exp;
        if (rx_q.size() == 0) begin
            chk({name, "_underflow"}, 32'd1, 32'd0);
        end else begin
            exp = rx_q.pop_front();
            chk({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
            chk({name, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int lat;
        tbl[0] = '{3'b001, 8'h01, 3'b000, 1'b1};
        tbl[1] = '{3'b001, 8'h02, 3'b000, 1'b1};
        tbl[2] = '{3'b001, 8'h03, 3'b000, 1'b1};
        tbl[3] = '{3'b001, 8'h04, 3'b010, 1'b1};
        tbl[4] = '{3'b001, 8'h05, 3'b110, 1'b1};

        rst = 1'b1; upd = 1'b0; reg_q = 8'h00; reg_addr = 3'b000;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_status", {29'd0, status}, 32'd0);
        chk("rst_reg_d", {24'd0, reg_d}, 32'h00);
        chk("rst_ovf", {31'd0, rx_ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single RXWR, latency bounded
        rx_q.push_back(8'hA5);
        reg_addr = 3'b001; reg_q = 8'hA5; upd = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) upd = 1'b0;
            if (rx_valid) break;
        end
        chk("rxwr_latency_ok", {31'd0, (lat <= 4)}, 32'd1);
        repeat (2) @(negedge clk);
        pop_check("rxwr_a5");
        chk("rxwr_empty", {31'd0, rx_valid}, 32'd0);

        // fill past depth from table
        for (int i = 0; i < 5; i++) begin
            jtag_cmd(tbl[i].code, tbl[i].data, 1, 3);
            chk($sformatf("fill%0d_status", i), {29'd0, status}, {29'd0, tbl[i].exp_status});
            chk($sformatf("fill%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_valid});
        end
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
        chk("drain_empty", {31'd0, rx_valid}, 32'd0);
        chk("drain_status", {29'd0, status}, 32'b100);

        // reset mid-traffic with a strobe in flight
        jtag_cmd(3'b001, 8'hB1, 1, 3);
        jtag_cmd(3'b001, 8'hB2, 1, 3);
        tx_data = 8'h99; tx_valid = 1'b1;
        @(negedge clk);
        reg_addr = 3'b001; reg_q = 8'hB3; upd = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("mrst_status", {29'd0, status}, 32'd0);
        chk("mrst_ovf", {31'd0, rx_ovf}, 32'd0);
        rx_q.delete();
        @(negedge clk);
        upd = 1'b0; tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_strobe_lost", {31'd0, rx_valid}, 32'd0);
        chk("mrst_reg_d", {24'd0, reg_d}, 32'h00);

        // push into full FIFO with pop in strobe cycle
        for (int i = 1; i <= 4; i++) jtag_cmd(3'b001, 8'(i), 1, 3);
        chk("full_status", {29'd0, status}, 32'b010);
        @(negedge clk);
        reg_addr = 3'b001; reg_q = 8'h77; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1;
        chk("pp_head", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
        rx_q.push_back(8'h77);
        @(negedge clk);
        rx_ready = 1'b0;
        chk("pp_status", {29'd0, status}, 32'b010);
        chk("pp_ovf", {31'd0, rx_ovf}, 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) pop_check($sformatf("pp_drain%0d", i));
        chk("pp_empty", {31'd0, rx_valid}, 32'd0);

        // TX holding register handshake
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        chk("tx1_reg_d", {24'd0, reg_d}, 32'h3C);
        chk("tx1_ready", {31'd0, tx_ready}, 32'd0);
        chk("tx1_status", {29'd0, status}, 32'b001);
        tx_data = 8'h4D;
        repeat (3) @(negedge clk);
        chk("tx2_held", {24'd0, reg_d}, 32'h3C);
        jtag_cmd(3'b010, 8'h00, 1, 2);
        chk("txack_ready", {31'd0, tx_ready}, 32'd1);
        chk("txack_reg_d", {24'd0, reg_d}, 32'h3C);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx2_reg_d", {24'd0, reg_d}, 32'h4D);
        chk("tx2_ready", {31'd0, tx_ready}, 32'd0);
        jtag_cmd(3'b010, 8'h00, 1, 3);
        jtag_cmd(3'b010, 8'h00, 1, 3);
        chk("txack_idle_ready", {31'd0, tx_ready}, 32'd1);
        chk("txack_idle_status", {29'd0, status}, 32'b000);

        // long update pulses execute once
        jtag_cmd(3'b001, 8'h11, 10, 3);
        pop_check("hold_rxwr");
        chk("hold_rxwr_once", {31'd0, rx_valid}, 32'd0);
        for (int i = 1; i <= 5; i++) jtag_cmd(3'b001, 8'(i), 1, 3);
        tx_data = 8'hE1; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("pre_status", {29'd0, status}, 32'b111);
        jtag_cmd(3'b111, 8'hEE, 10, 3);
        chk("c7_status", {29'd0, status}, 32'b111);
        chk("c7_head", {24'd0, rx_data}, {24'd0, rx_q[0]});
        jtag_cmd(3'b011, 8'h00, 10, 3);
        chk("flush_status", {29'd0, status}, 32'b000);
        chk("flush_valid", {31'd0, rx_valid}, 32'd0);
        chk("flush_ovf", {31'd0, rx_ovf}, 32'd0);
        chk("flush_ready", {31'd0, tx_ready}, 32'd1);
        chk("flush_reg_d", {24'd0, reg_d}, 32'hE1);
        jtag_cmd(3'b001, 8'h5A, 1, 3);
        pop_check("post_flush");
        chk("post_flush_empty", {31'd0, rx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
